// File: rtl/pulse_seq_pkg.sv
// ----------------------------------------------------------------------------
// pulse_seq_pkg
// Shared types and sizes for the pulse sequencer and its step table.
//   N      : width of a step's period field (cycles between pulses)
//   R      : width of a step's repeat-count field
//   STEPS  : number of table entries (power of two, at least 2)
//   IDX_W  : width of a table index
//   state_t: sequencer FSM states
//   step_t : one table entry {period, repeat_cnt, last}
// ----------------------------------------------------------------------------
package pulse_seq_pkg;

    localparam int N     = 8;
    localparam int R     = 4;
    localparam int STEPS = 4;
    localparam int IDX_W = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    // "repeat" is a reserved word, so the count field is repeat_cnt.
    typedef struct packed {
        logic [N-1:0] period;
        logic [R-1:0] repeat_cnt;
        logic         last;
    } step_t;

endpackage

// File: rtl/seq_step_table.sv
// ----------------------------------------------------------------------------
// seq_step_table
// STEPS-entry register file of step_t. One synchronous write port, one
// combinational read port; every entry clears to zero on reset.
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset, clears all entries
//   i_wr_en    write i_wr_data into entry i_wr_addr on this edge
//   i_wr_addr  entry to write
//   i_wr_data  entry contents to write
//   i_rd_addr  entry to read
//   o_rd_data  contents of entry i_rd_addr
// ----------------------------------------------------------------------------
module seq_step_table
    import pulse_seq_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  step_t            i_wr_data,
    input  logic [IDX_W-1:0] i_rd_addr,
    output step_t            o_rd_data
);

    step_t r_table [STEPS];

    // Table storage: a reset wipes the whole program back to P=0, C=0,
    // last=0 so a start with no programming skips straight through.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < STEPS; i++) begin
                r_table[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_table[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_table[i_rd_addr];

endmodule

// File: rtl/pulse_sequencer.sv
// ----------------------------------------------------------------------------
// pulse_sequencer
// Walks a small table of {period, repeat count, last} steps and emits a pulse
// train: each step produces C pulses spaced P cycles apart, then the program
// moves to the next step, finishes, or loops back to step 0.
// Ports:
//   i_clk, i_rst    clock and synchronous active-high reset
//   i_cfg_wr        write a table entry (only honoured while IDLE)
//   i_cfg_addr      table index to write
//   i_cfg_period    period P of the entry
//   i_cfg_repeat    repeat count C of the entry
//   i_cfg_last      entry is the final step of the program
//   i_start         begin at step 0 (only honoured while IDLE)
//   i_loop          at end of program: 1 restarts at step 0, 0 finishes
//   i_abort         return to IDLE from any non-IDLE state
//   o_pulse         one-cycle pulse output
//   o_busy          state is LOAD or RUN
//   o_done          one-cycle flag on normal completion
//   o_step_idx      index of the current step
// ----------------------------------------------------------------------------
module pulse_sequencer
    import pulse_seq_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cfg_wr,
    input  logic [IDX_W-1:0] i_cfg_addr,
    input  logic [N-1:0]     i_cfg_period,
    input  logic [R-1:0]     i_cfg_repeat,
    input  logic             i_cfg_last,
    input  logic             i_start,
    input  logic             i_loop,
    input  logic             i_abort,
    output logic             o_pulse,
    output logic             o_busy,
    output logic             o_done,
    output logic [IDX_W-1:0] o_step_idx
);

    state_t           r_state;
    logic [IDX_W-1:0] r_step_idx;
    logic [N-1:0]     r_period;
    logic [N-1:0]     r_count;
    logic [R-1:0]     r_repeat;
    logic [R-1:0]     r_pulse_cnt;
    logic             r_last;

    step_t            w_entry;
    step_t            w_wr_data;
    logic             w_wr_en;
    logic             w_skip;
    logic             w_hit;
    logic             w_step_done;
    logic             w_prog_end;
    state_t           w_end_state;
    logic [IDX_W-1:0] w_end_idx;

    // The table only accepts writes while IDLE, so a running program can
    // never be altered underneath itself.
    assign w_wr_en   = i_cfg_wr && (r_state == IDLE);
    assign w_wr_data = step_t'{period: i_cfg_period, repeat_cnt: i_cfg_repeat, last: i_cfg_last};

    seq_step_table u_table (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (i_cfg_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (r_step_idx),
        .o_rd_data (w_entry)
    );

    // A step with nothing to emit is skipped straight from LOAD.
    assign w_skip      = (w_entry.period == '0) || (w_entry.repeat_cnt == '0);
    assign w_hit       = (r_state == RUN) && (r_count == r_period - N'(1));
    assign w_step_done = w_hit && (r_pulse_cnt == r_repeat - R'(1));

    // End-of-step decision shared by the LOAD skip path and the C-th pulse
    // in RUN. In LOAD the working registers are not yet valid, so the last
    // flag comes straight from the table.
    always_comb begin
        w_prog_end  = ((r_state == LOAD) ? w_entry.last : r_last) ||
                      (r_step_idx == IDX_W'(STEPS - 1));
        w_end_state = LOAD;
        w_end_idx   = r_step_idx + IDX_W'(1);
        if (w_prog_end) begin
            if (i_loop) begin
                w_end_idx = '0;
            end else begin
                w_end_state = DONE;
                w_end_idx   = r_step_idx;
            end
        end
    end

    // Sequencer FSM with its interval and pulse counters. Abort beats every
    // transition (only reset is stronger) and has no effect in IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_step_idx  <= '0;
            r_period    <= '0;
            r_repeat    <= '0;
            r_last      <= 1'b0;
            r_count     <= '0;
            r_pulse_cnt <= '0;
        end else if (i_abort && (r_state != IDLE)) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state    <= LOAD;
                        r_step_idx <= '0;
                    end
                end
                LOAD: begin
                    r_period    <= w_entry.period;
                    r_repeat    <= w_entry.repeat_cnt;
                    r_last      <= w_entry.last;
                    r_count     <= '0;
                    r_pulse_cnt <= '0;
                    if (w_skip) begin
                        r_state    <= w_end_state;
                        r_step_idx <= w_end_idx;
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_hit) begin
                        r_count     <= '0;
                        r_pulse_cnt <= r_pulse_cnt + R'(1);
                        if (w_step_done) begin
                            r_state    <= w_end_state;
                            r_step_idx <= w_end_idx;
                        end
                    end else begin
                        r_count <= r_count + N'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state; abort masks the pulse in its own cycle.
    assign o_pulse    = w_hit && !i_abort;
    assign o_busy     = (r_state == LOAD) || (r_state == RUN);
    assign o_done     = (r_state == DONE);
    assign o_step_idx = r_step_idx;

endmodule

// File: tb/tb_pulse_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pulse_sequencer
// Self-checking bench for pulse_sequencer. Directed scenarios use cycle
// numbers counted from the cycle in which start is driven (cycle 0); the
// randomized scenario derives its expected pulse/busy/done/step schedule
// arithmetically from a shadow copy of the table.
// ----------------------------------------------------------------------------
module tb_pulse_sequencer;
    import pulse_seq_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfgWr;
    logic [IDX_W-1:0] cfgAddr;
    logic [N-1:0]     cfgPeriod;
    logic [R-1:0]     cfgRepeat;
    logic             cfgLast;
    logic             start;
    logic             loopEn;
    logic             abort;
    logic             pulse;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] stepIdx;

    int vectors     = 0;
    int miscompares = 0;

    // Shadow of the programmed table used by the reference schedule.
    int tblP [STEPS];
    int tblC [STEPS];
    bit tblL [STEPS];

    always #5 clk = ~clk;

    pulse_sequencer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cfg_wr     (cfgWr),
        .i_cfg_addr   (cfgAddr),
        .i_cfg_period (cfgPeriod),
        .i_cfg_repeat (cfgRepeat),
        .i_cfg_last   (cfgLast),
        .i_start      (start),
        .i_loop       (loopEn),
        .i_abort      (abort),
        .o_pulse      (pulse),
        .o_busy       (busy),
        .o_done       (done),
        .o_step_idx   (stepIdx)
    );

    // Move to just after the next rising edge, where inputs are driven.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearShadow();
        for (int i = 0; i < STEPS; i++) begin
            tblP[i] = 0;
            tblC[i] = 0;
            tblL[i] = 1'b0;
        end
    endtask

    // Program one table entry while the sequencer is IDLE.
    task automatic applyStimulus(input int a, input int p, input int c, input bit l);
        cfgAddr   = IDX_W'(a);
        cfgPeriod = N'(p);
        cfgRepeat = R'(c);
        cfgLast   = l;
        cfgWr     = 1'b1;
        nextCycle();
        cfgWr     = 1'b0;
        tblP[a]   = p;
        tblC[a]   = c;
        tblL[a]   = l;
    endtask

    // Reset values of every output while reset is held.
    task automatic test_reset();
        rst = 1'b1;
        nextCycle();
        nextCycle();
        @(negedge clk);
        vectors++;
        if (pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL reset pulse got %b want 0", pulse); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset busy got %b want 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset done got %b want 0", done); end
        vectors++;
        if (stepIdx !== '0) begin miscompares++; $display("[TB] FAIL reset step_idx got %0d want 0", stepIdx); end
        rst = 1'b0;
        clearShadow();
        nextCycle();
    endtask

    // Two-step program {P=3,C=2},{P=1,C=3,last}.
    task automatic test_basic();
        logic [63:0] pm;
        logic [63:0] bm;
        applyStimulus(0, 3, 2, 1'b0);
        applyStimulus(1, 1, 3, 1'b1);
        pm = '0; pm[4] = 1; pm[7] = 1; pm[9] = 1; pm[10] = 1; pm[11] = 1;
        bm = '0; for (int c = 1; c <= 11; c++) bm[c] = 1;
        loopEn = 1'b0;
        start  = 1'b1;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            vectors++;
            if (pulse !== pm[c]) begin miscompares++; $display("[TB] FAIL basic pulse c=%0d got %b want %b", c, pulse, pm[c]); end
            vectors++;
            if (busy !== bm[c]) begin miscompares++; $display("[TB] FAIL basic busy c=%0d got %b want %b", c, busy, bm[c]); end
            vectors++;
            if (done !== (c == 12)) begin miscompares++; $display("[TB] FAIL basic done c=%0d got %b want %b", c, done, c == 12); end
            if (c >= 1) begin
                vectors++;
                if (stepIdx !== IDX_W'((c >= 8) ? 1 : 0)) begin miscompares++; $display("[TB] FAIL basic step_idx c=%0d got %0d want %0d", c, stepIdx, (c >= 8) ? 1 : 0); end
            end
            nextCycle();
            start = 1'b0;
        end
    endtask

    // Middle step with P=0 is skipped; each LOAD costs one cycle.
    task automatic test_skip();
        logic [63:0] pm;
        int ei;
        applyStimulus(0, 2, 1, 1'b0);
        applyStimulus(1, 0, 5, 1'b0);
        applyStimulus(2, 2, 1, 1'b1);
        pm = '0; pm[3] = 1; pm[7] = 1;
        start = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            ei = (c <= 3) ? 0 : ((c == 4) ? 1 : 2);
            vectors++;
            if (pulse !== pm[c]) begin miscompares++; $display("[TB] FAIL skip pulse c=%0d got %b want %b", c, pulse, pm[c]); end
            vectors++;
            if (busy !== (c >= 1 && c <= 7)) begin miscompares++; $display("[TB] FAIL skip busy c=%0d got %b want %b", c, busy, c >= 1 && c <= 7); end
            vectors++;
            if (done !== (c == 8)) begin miscompares++; $display("[TB] FAIL skip done c=%0d got %b want %b", c, done, c == 8); end
            if (c >= 1) begin
                vectors++;
                if (stepIdx !== IDX_W'(ei)) begin miscompares++; $display("[TB] FAIL skip step_idx c=%0d got %0d want %0d", c, stepIdx, ei); end
            end
            nextCycle();
            start = 1'b0;
        end
    endtask

    // Single last step looping; loop dropped before the fourth pulse.
    task automatic test_loop();
        applyStimulus(0, 2, 1, 1'b1);
        loopEn = 1'b1;
        start  = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            vectors++;
            if (pulse !== (c == 3 || c == 6 || c == 9 || c == 12)) begin miscompares++; $display("[TB] FAIL loop pulse c=%0d got %b", c, pulse); end
            vectors++;
            if (busy !== (c >= 1 && c <= 12)) begin miscompares++; $display("[TB] FAIL loop busy c=%0d got %b want %b", c, busy, c >= 1 && c <= 12); end
            vectors++;
            if (done !== (c == 13)) begin miscompares++; $display("[TB] FAIL loop done c=%0d got %b want %b", c, done, c == 13); end
            if (c >= 1) begin
                vectors++;
                if (stepIdx !== '0) begin miscompares++; $display("[TB] FAIL loop step_idx c=%0d got %0d want 0", c, stepIdx); end
            end
            nextCycle();
            start = 1'b0;
            if (c + 1 == 11) loopEn = 1'b0;
        end
    endtask

    // Four P=1,C=1 steps with no last flag; a restart resets step_idx and
    // is then aborted from LOAD.
    task automatic test_full_table();
        int ei;
        for (int s = 0; s < STEPS; s++) applyStimulus(s, 1, 1, 1'b0);
        start = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            ei = (c >= 11) ? 0 : ((c >= 7) ? 3 : (c - 1) / 2);
            vectors++;
            if (pulse !== (c == 2 || c == 4 || c == 6 || c == 8)) begin miscompares++; $display("[TB] FAIL full pulse c=%0d got %b", c, pulse); end
            vectors++;
            if (busy !== ((c >= 1 && c <= 8) || c == 11)) begin miscompares++; $display("[TB] FAIL full busy c=%0d got %b", c, busy); end
            vectors++;
            if (done !== (c == 9)) begin miscompares++; $display("[TB] FAIL full done c=%0d got %b want %b", c, done, c == 9); end
            if (c >= 1) begin
                vectors++;
                if (stepIdx !== IDX_W'(ei)) begin miscompares++; $display("[TB] FAIL full step_idx c=%0d got %0d want %0d", c, stepIdx, ei); end
            end
            nextCycle();
            start = (c + 1 == 10);
            abort = (c + 1 == 11);
        end
    endtask

    // Abort on the cycle of the first pulse, with a write attempted mid-RUN;
    // a clean rerun shows the table kept its original entry.
    task automatic test_abort();
        applyStimulus(0, 4, 3, 1'b1);
        start = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            vectors++;
            if (pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL abort pulse c=%0d got %b want 0", c, pulse); end
            vectors++;
            if (busy !== (c >= 1 && c <= 5)) begin miscompares++; $display("[TB] FAIL abort busy c=%0d got %b want %b", c, busy, c >= 1 && c <= 5); end
            vectors++;
            if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL abort done c=%0d got %b want 0", c, done); end
            nextCycle();
            start = 1'b0;
            cfgWr = (c + 1 == 3);
            if (c + 1 == 3) begin
                cfgAddr = '0; cfgPeriod = N'(1); cfgRepeat = R'(1); cfgLast = 1'b0;
            end
            abort = (c + 1 == 5);
        end
        start = 1'b1;
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            vectors++;
            if (pulse !== (c == 5 || c == 9 || c == 13)) begin miscompares++; $display("[TB] FAIL rerun pulse c=%0d got %b", c, pulse); end
            vectors++;
            if (busy !== (c >= 1 && c <= 13)) begin miscompares++; $display("[TB] FAIL rerun busy c=%0d got %b", c, busy); end
            vectors++;
            if (done !== (c == 14)) begin miscompares++; $display("[TB] FAIL rerun done c=%0d got %b want %b", c, done, c == 14); end
            nextCycle();
            start = 1'b0;
        end
    endtask

    // Reset in the middle of RUN, then start on the cleared table.
    task automatic test_reset_mid_run();
        applyStimulus(0, 4, 3, 1'b1);
        start = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            vectors++;
            if (pulse !== (c == 5)) begin miscompares++; $display("[TB] FAIL rstrun pulse c=%0d got %b want %b", c, pulse, c == 5); end
            vectors++;
            if (busy !== (c >= 1 && c <= 5)) begin miscompares++; $display("[TB] FAIL rstrun busy c=%0d got %b", c, busy); end
            vectors++;
            if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL rstrun done c=%0d got %b want 0", c, done); end
            if (c == 6) begin
                vectors++;
                if (stepIdx !== '0) begin miscompares++; $display("[TB] FAIL rstrun step_idx got %0d want 0", stepIdx); end
            end
            nextCycle();
            start = 1'b0;
            rst   = (c + 1 == 5);
        end
        clearShadow();
        start = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            vectors++;
            if (pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL cleared pulse c=%0d got %b want 0", c, pulse); end
            vectors++;
            if (busy !== (c >= 1 && c <= 4)) begin miscompares++; $display("[TB] FAIL cleared busy c=%0d got %b", c, busy); end
            vectors++;
            if (done !== (c == 5)) begin miscompares++; $display("[TB] FAIL cleared done c=%0d got %b want %b", c, done, c == 5); end
            if (c >= 1) begin
                vectors++;
                if (stepIdx !== IDX_W'((c >= 4) ? 3 : c - 1)) begin miscompares++; $display("[TB] FAIL cleared step_idx c=%0d got %0d want %0d", c, stepIdx, (c >= 4) ? 3 : c - 1); end
            end
            nextCycle();
            start = 1'b0;
        end
    endtask

    // Random tables, with entry 0 rewritten in the same cycle as start.
    // Expected schedule: step s starting at LOAD cycle t lasts 1 cycle if
    // skipped, else 1+P*C cycles with pulses at t+k*P (k=1..C); done follows
    // the final step and step_idx holds afterwards.
    task automatic test_random();
        bit ep [128];
        bit eb [128];
        bit ed [128];
        int ei [128];
        int t;
        int len;
        int endCyc;
        for (int it = 0; it < 10; it++) begin
            for (int s = 0; s < STEPS; s++) begin
                applyStimulus(s, int'($urandom_range(6, 0)), int'($urandom_range(4, 0)), ($urandom_range(3, 0) == 0));
            end
            cfgAddr   = '0;
            cfgPeriod = N'($urandom_range(6, 0));
            cfgRepeat = R'($urandom_range(4, 0));
            cfgLast   = ($urandom_range(3, 0) == 0);
            tblP[0]   = int'(cfgPeriod);
            tblC[0]   = int'(cfgRepeat);
            tblL[0]   = cfgLast;
            for (int i = 0; i < 128; i++) begin
                ep[i] = 0; eb[i] = 0; ed[i] = 0; ei[i] = -1;
            end
            t = 1;
            for (int s = 0; s < STEPS; s++) begin
                len = (tblP[s] == 0 || tblC[s] == 0) ? 1 : 1 + tblP[s] * tblC[s];
                for (int k = 0; k < len; k++) begin
                    eb[t + k] = 1;
                    ei[t + k] = s;
                end
                if (len > 1) begin
                    for (int k = 1; k <= tblC[s]; k++) ep[t + k * tblP[s]] = 1;
                end
                t = t + len;
                if (tblL[s] || s == STEPS - 1) break;
            end
            ed[t]     = 1;
            ei[t]     = ei[t - 1];
            ei[t + 1] = ei[t - 1];
            endCyc    = t + 1;
            cfgWr  = 1'b1;
            start  = 1'b1;
            loopEn = 1'b0;
            for (int c = 0; c <= endCyc; c++) begin
                @(negedge clk);
                vectors++;
                if (pulse !== ep[c]) begin miscompares++; $display("[TB] FAIL rand%0d pulse c=%0d got %b want %b", it, c, pulse, ep[c]); end
                vectors++;
                if (busy !== eb[c]) begin miscompares++; $display("[TB] FAIL rand%0d busy c=%0d got %b want %b", it, c, busy, eb[c]); end
                vectors++;
                if (done !== ed[c]) begin miscompares++; $display("[TB] FAIL rand%0d done c=%0d got %b want %b", it, c, done, ed[c]); end
                if (c >= 1) begin
                    vectors++;
                    if (stepIdx !== IDX_W'(ei[c])) begin miscompares++; $display("[TB] FAIL rand%0d step_idx c=%0d got %0d want %0d", it, c, stepIdx, ei[c]); end
                end
                nextCycle();
                cfgWr = 1'b0;
                start = 1'b0;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        cfgWr     = 1'b0;
        cfgAddr   = '0;
        cfgPeriod = '0;
        cfgRepeat = '0;
        cfgLast   = 1'b0;
        start     = 1'b0;
        loopEn    = 1'b0;
        abort     = 1'b0;
        clearShadow();
        test_reset();
        test_basic();
        test_skip();
        test_loop();
        test_full_table();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
